traffic_phase_scheduler: RTL

- Sequences a shared intersection between the main road and N_REQ side requesters (pedestrian crossings and side-street sensors).
- Main road holds green by default. Latched requests are served one at a time, in round-robin order, each framed by all-red clearance.
- An emergency input pre-empts any phase.
- Sits between the debounced button/sensor inputs and the lamp drivers and 7-segment countdown.

---
 rtl/tps_pkg.sv | 37 +++
 rtl/rr_pick.sv | 36 +++
 rtl/traffic_phase_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tps_pkg.sv
// tps_pkg: shared types and constants for the traffic phase scheduler.
//   tps_state_t    - phase encoding used by the scheduler FSM
//   secbits()      - width of the seconds-left countdown for a timing set
//   DEF_*          - default timing constants (seconds) and clock rate
package tps_pkg;

    typedef enum logic [2:0] {
        S_RST,
        S_MAIN,
        S_CLR_IN,
        S_SERVE,
        S_CLR_OUT,
        S_EMERG
    } tps_state_t;

    localparam int DEF_FPGAFREQ  = 50_000_000;
    localparam int DEF_N_REQ     = 4;
    localparam int DEF_T_RESET   = 3;
    localparam int DEF_T_MINMAIN = 18;
    localparam int DEF_T_SERVE   = 5;
    localparam int DEF_T_CLEAR   = 2;

    // Countdown width: clog2 of the longest phase, never narrower than 1 bit.
    function automatic int secbits(input int t_reset, input int t_minmain,
                                   input int t_serve, input int t_clear);
        int longest;
        int bits;
        longest = t_reset;
        if (t_minmain > longest) longest = t_minmain;
        if (t_serve > longest)   longest = t_serve;
        if (t_clear > longest)   longest = t_clear;
        bits = $clog2(longest);
        if (bits < 1) bits = 1;
        return bits;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   pending - request vector to choose from
//   ptr     - index of the most recently served requester
//   valid   - at least one pending bit is set; index is meaningful only then
//   index   - first set bit found searching upward from ptr+1, wrapping to 0
module rr_pick
    import tps_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         pending,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] index
);

    localparam int IDXW = $clog2(N_REQ);

    logic [IDXW-1:0] cand;

    // Walk offsets 1..N_REQ from the pointer; the first hit wins, so the
    // last-served requester is considered only when nobody else is waiting.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDXW'((int'(ptr) + k) % N_REQ);
            if (!valid && pending[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: sequences an intersection between the main road
// and N_REQ side requesters. Main road is green by default; latched requests
// are served one at a time in round-robin order, each framed by all-red
// clearance. Emergency pre-empts any phase.
//   clk, reset  - system clock, asynchronous active-high reset
//   req         - request levels (asynchronous, synchronised here)
//   emerg       - emergency pre-emption (asynchronous, synchronised here)
//   main_go     - main road green
//   grant       - one-hot grant to the requester being served
//   all_red     - reset, clearance or emergency phase
//   emerg_ack   - emergency hold active
//   pending     - latched, not yet served requests
//   sec_left    - whole seconds left in the current timed phase, minus 1
module traffic_phase_scheduler
    import tps_pkg::*;
#(
    parameter int FPGAFREQ  = DEF_FPGAFREQ,
    parameter int N_REQ     = DEF_N_REQ,
    parameter int T_RESET   = DEF_T_RESET,
    parameter int T_MINMAIN = DEF_T_MINMAIN,
    parameter int T_SERVE   = DEF_T_SERVE,
    parameter int T_CLEAR   = DEF_T_CLEAR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic                   emerg,
    output logic                   main_go,
    output logic [N_REQ-1:0]       grant,
    output logic                   all_red,
    output logic                   emerg_ack,
    output logic [N_REQ-1:0]       pending,
    output logic [secbits(T_RESET, T_MINMAIN, T_SERVE, T_CLEAR)-1:0] sec_left
);

    localparam int SECBITS = secbits(T_RESET, T_MINMAIN, T_SERVE, T_CLEAR);
    localparam int DIVBITS = (FPGAFREQ > 1) ? $clog2(FPGAFREQ) : 1;
    localparam int IDXW    = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_meta;
    logic [N_REQ-1:0]   sync_req;
    logic               emerg_meta;
    logic               sync_emerg;

    tps_state_t         state;
    tps_state_t         next_state;
    logic               state_change;
    logic [DIVBITS-1:0] div_cnt;
    logic               tick;
    logic               expire;
    logic               min_done;
    logic [IDXW-1:0]    rr_ptr;
    logic [IDXW-1:0]    winner;
    logic [IDXW-1:0]    pick_index;
    logic               pick_valid;
    logic [N_REQ-1:0]   win_onehot;
    logic [N_REQ-1:0]   pend_clear;
    logic [N_REQ-1:0]   pend_requeue;
    logic [SECBITS-1:0] load_val;

    // Two-flop synchronisers for the asynchronous inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_meta   <= '0;
            sync_req   <= '0;
            emerg_meta <= 1'b0;
            sync_emerg <= 1'b0;
        end else begin
            req_meta   <= req;
            sync_req   <= req_meta;
            emerg_meta <= emerg;
            sync_emerg <= emerg_meta;
        end
    end

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .pending (pending),
        .ptr     (rr_ptr),
        .valid   (pick_valid),
        .index   (pick_index)
    );

    assign tick   = (div_cnt == DIVBITS'(FPGAFREQ - 1));
    assign expire = tick && (sec_left == '0);

    // Next phase. Emergency wins over everything; once the main-road minimum
    // has elapsed (including on the expiring cycle itself) any pending
    // request moves us to clearance without waiting for another tick.
    always_comb begin
        next_state = state;
        if (sync_emerg) begin
            next_state = S_EMERG;
        end else begin
            case (state)
                S_RST:     if (expire) next_state = S_MAIN;
                S_MAIN:    if ((min_done || expire) && pick_valid) next_state = S_CLR_IN;
                S_CLR_IN:  if (expire) next_state = S_SERVE;
                S_SERVE:   if (expire) next_state = S_CLR_OUT;
                S_CLR_OUT: if (expire) next_state = S_MAIN;
                S_EMERG:   next_state = S_CLR_OUT;
                default:   next_state = S_RST;
            endcase
        end
    end

    always_comb begin
        case (next_state)
            S_RST:               load_val = SECBITS'(T_RESET - 1);
            S_MAIN:              load_val = SECBITS'(T_MINMAIN - 1);
            S_CLR_IN, S_CLR_OUT: load_val = SECBITS'(T_CLEAR - 1);
            S_SERVE:             load_val = SECBITS'(T_SERVE - 1);
            default:             load_val = '0;
        endcase
    end

    assign state_change = (next_state != state);
    assign win_onehot   = N_REQ'(1) << winner;
    // Entering a serve consumes the winner's request; being pre-empted out
    // of a serve puts it back so it is not lost.
    assign pend_clear   = (state_change && next_state == S_SERVE) ? win_onehot : '0;
    assign pend_requeue = (state == S_SERVE && next_state == S_EMERG) ? win_onehot : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_RST;
            div_cnt   <= '0;
            sec_left  <= SECBITS'(T_RESET - 1);
            min_done  <= 1'b0;
            rr_ptr    <= IDXW'(N_REQ - 1);
            winner    <= '0;
            pending   <= '0;
            main_go   <= 1'b0;
            grant     <= '0;
            all_red   <= 1'b1;
            emerg_ack <= 1'b0;
        end else begin
            state   <= next_state;
            pending <= (pending | sync_req | pend_requeue) & ~pend_clear;

            if (state_change) begin
                // Restart the second divider so each phase is exactly
                // T * FPGAFREQ cycles long.
                div_cnt   <= '0;
                sec_left  <= load_val;
                min_done  <= 1'b0;
                main_go   <= (next_state == S_MAIN);
                grant     <= (next_state == S_SERVE) ? win_onehot : '0;
                all_red   <= (next_state == S_RST) || (next_state == S_CLR_IN) ||
                             (next_state == S_CLR_OUT) || (next_state == S_EMERG);
                emerg_ack <= (next_state == S_EMERG);
                if (next_state == S_CLR_IN) winner <= pick_index;
                if (next_state == S_SERVE)  rr_ptr <= winner;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick && sec_left != '0) sec_left <= sec_left - 1'b1;
                if (state == S_MAIN && expire) min_done <= 1'b1;
            end
        end
    end

endmodule
